// File: rtl/conv_n_m.sv
// Valid-ins convolution: loads N x samples and M f coefficients, then emits
// y[i] = sum_j x[i+j]*f[j] for i = 0..N-M with one registered-read MAC per product.
module conv_n_m #(
   parameter int T    = 8,
   parameter int N    = 8,
   parameter int M    = 4,
   parameter int RELU = 0,
   localparam int YW  = 2*T + $clog2(M)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [T-1:0]         s_data_in_x,
   input  logic                 s_valid_x,
   output logic                 s_ready_x,
   input  logic [T-1:0]         s_data_in_f,
   input  logic                 s_valid_f,
   output logic                 s_ready_f,
   output logic [YW-1:0]        m_data_out_y,
   output logic                 m_valid_y,
   input  logic                 m_ready_y
);

   // Handshakes: a word moves only on a rising edge where valid and ready are both 1;
   // ready is a function of state only, never of valid.

   localparam int CXW = $clog2(N + 1);
   localparam int CFW = $clog2(M + 1);
   localparam int IW  = $clog2(N);
   localparam int FAW = $clog2(M);
   localparam int KW  = $clog2(M + 1);

   localparam logic [CXW-1:0] X_FULL   = CXW'(N);
   localparam logic [CFW-1:0] F_FULL   = CFW'(M);
   localparam logic [IW-1:0]  LAST_IDX = IW'(N - M);
   localparam logic [KW-1:0]  K_LAST   = KW'(M);

   typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;
   state_t state, state_next;

   logic [CXW-1:0]         cnt_x;
   logic [CFW-1:0]         cnt_f;
   logic [IW-1:0]          out_idx;
   logic [KW-1:0]          mac_cnt;
   logic                   rdy_en;
   logic signed [T-1:0]    x_buf [N];
   logic signed [T-1:0]    f_buf [M];
   logic signed [T-1:0]    x_rd, f_rd;
   logic signed [2*T-1:0]  prod;
   logic signed [YW-1:0]   prod_ext, acc, acc_sum, y_next, y_q;
   logic [IW-1:0]          x_addr;
   logic [FAW-1:0]         f_addr;
   logic                   x_fire, f_fire, y_fire, mac_entry, run_done;

   assign x_fire    = s_valid_x && s_ready_x;
   assign f_fire    = s_valid_f && s_ready_f;
   assign y_fire    = m_valid_y && m_ready_y;
   assign run_done  = y_fire && (out_idx == LAST_IDX);
   assign mac_entry = (state_next == MAC) && (state != MAC);

   assign x_addr   = out_idx + IW'(mac_cnt);
   assign f_addr   = mac_cnt[FAW-1:0];
   assign prod     = x_rd * f_rd;
   assign prod_ext = {{(YW-2*T){prod[2*T-1]}}, prod};
   assign acc_sum  = acc + prod_ext;

   always_comb begin
      y_next = acc_sum;
      if (RELU != 0 && acc_sum < 0) y_next = '0;
   end

   assign m_data_out_y = y_q;

   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD: if (cnt_x == X_FULL && cnt_f == F_FULL) state_next = MAC;
         MAC:  if (mac_cnt == K_LAST) state_next = OUT;
         OUT:  if (y_fire) state_next = run_done ? LOAD : MAC;
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      s_ready_x = rdy_en && (state == LOAD) && (cnt_x != X_FULL);
      s_ready_f = rdy_en && (state == LOAD) && (cnt_f != F_FULL);
      m_valid_y = (state == OUT);
   end

   // Buffer contents are never cleared; the word counts alone define what is valid.
   always_ff @(posedge clk) begin
      if (x_fire) x_buf[cnt_x[IW-1:0]]  <= s_data_in_x;
      if (f_fire) f_buf[cnt_f[FAW-1:0]] <= s_data_in_f;
   end

   // MAC step k issues read k and accumulates the product read at step k-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_x   <= '0;
         cnt_f   <= '0;
         out_idx <= '0;
         mac_cnt <= '0;
         acc     <= '0;
         y_q     <= '0;
         x_rd    <= '0;
         f_rd    <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (x_fire) cnt_x <= cnt_x + 1'b1;
         if (f_fire) cnt_f <= cnt_f + 1'b1;
         if (mac_entry) begin
            acc     <= '0;
            mac_cnt <= '0;
         end else if (state == MAC) begin
            if (mac_cnt != K_LAST) begin
               x_rd    <= x_buf[x_addr];
               f_rd    <= f_buf[f_addr];
               mac_cnt <= mac_cnt + 1'b1;
            end
            if (mac_cnt != '0)     acc <= acc_sum;
            if (mac_cnt == K_LAST) y_q <= y_next;
         end
         if (y_fire) begin
            if (run_done) begin
               out_idx <= '0;
               cnt_x   <= '0;
               cnt_f   <= '0;
            end else begin
               out_idx <= out_idx + 1'b1;
            end
         end
      end
   end

endmodule
